// File: rtl/mem_access_seq.sv
// rtl/mem_access_seq.sv - LDUR/STUR data-memory sequencer with req/ack handshake and stall.
// Optional access timeout with a sticky fault is enabled by defining MEMSEQ_TIMEOUT_EN.
module mem_access_seq #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRd,
  input  logic              MemWr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              load_valid,
  output logic [DATA_W-1:0] rdata_q,
  output logic              fault
);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("mem_access_seq: TIMEOUT must be >= 2");
  end

`ifdef MEMSEQ_TIMEOUT_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_FAULT} state_t;
  localparam int CNT_W = $clog2(TIMEOUT);
  logic [CNT_W-1:0] count_q;
  logic             fault_q;
`else
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
`endif

  state_t            state_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rdata_r_q;
  logic              load_valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_r_q    <= '0;
      load_valid_q <= 1'b0;
`ifdef MEMSEQ_TIMEOUT_EN
      count_q      <= '0;
      fault_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          load_valid_q <= 1'b0;
          if (MemRd || MemWr) begin
            state_q     <= S_BUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= MemWr;
            mem_addr_q  <= addr;
            mem_wdata_q <= wdata;
`ifdef MEMSEQ_TIMEOUT_EN
            count_q     <= '0;
`endif
          end
        end
        S_BUSY: begin
          if (mem_ack) begin
            state_q      <= S_DONE;
            mem_req_q    <= 1'b0;
            load_valid_q <= !mem_we_q;
            if (!mem_we_q) begin
              rdata_r_q <= mem_rdata;
            end
`ifdef MEMSEQ_TIMEOUT_EN
          end else if (count_q == CNT_W'(TIMEOUT - 1)) begin
            state_q   <= S_FAULT;
            mem_req_q <= 1'b0;
            fault_q   <= 1'b1;
          end else begin
            count_q <= count_q + 1'b1;
`endif
          end
        end
        S_DONE: begin
          // Instruction retires here; a new MemRd/MemWr is only accepted from IDLE.
          load_valid_q <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: begin
`ifdef MEMSEQ_TIMEOUT_EN
          state_q <= S_FAULT;
`else
          state_q <= S_IDLE;
`endif
        end
      endcase
    end
  end

  // Stall must rise in the request cycle itself, before the FSM leaves IDLE.
  always_comb begin
    stall = 1'b0;
    case (state_q)
      S_IDLE:  stall = !reset && (MemRd || MemWr);
      S_BUSY:  stall = 1'b1;
`ifdef MEMSEQ_TIMEOUT_EN
      S_FAULT: stall = 1'b1;
`endif
      default: stall = 1'b0;
    endcase
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign rdata_q    = rdata_r_q;
  assign load_valid = load_valid_q;
`ifdef MEMSEQ_TIMEOUT_EN
  assign fault      = fault_q;
`else
  assign fault      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_seq.sv
// tb/tb_mem_access_seq.sv - randomized self-checking bench for mem_access_seq.
module tb_mem_access_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRd, MemWr;
  logic [63:0] addr, wdata;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        stall, load_valid;
  logic [63:0] rdata_q;
  logic        fault;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_rdata;

  always #5 clk = ~clk;

  mem_access_seq #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .MemRd(MemRd), .MemWr(MemWr),
    .addr(addr), .wdata(wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .stall(stall), .load_valid(load_valid),
    .rdata_q(rdata_q), .fault(fault)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One access: request cycle, k BUSY cycles with ack on the k-th, then the DONE cycle.
  task automatic do_access(input bit rd, input bit wr, input int k,
                           input logic [63:0] a, input logic [63:0] d, input logic [63:0] rdv);
    bit is_read = !wr;
    @(negedge clk);
    MemRd = rd; MemWr = wr; addr = a; wdata = d;
    mem_ack = 1'($urandom); mem_rdata = rnd64();
    #1;
    check_eq("req_stall", stall, 1);
    check_eq("req_memreq", mem_req, 0);
    for (int c = 1; c <= k; c++) begin
      @(negedge clk);
      MemRd = 0; MemWr = 0; addr = rnd64(); wdata = rnd64();
      mem_ack = (c == k);
      mem_rdata = (c == k) ? rdv : rnd64();
      #1;
      check_eq("busy_stall", stall, 1);
      check_eq("busy_memreq", mem_req, 1);
      check_eq("busy_we", mem_we, wr);
      check_eq("busy_addr", mem_addr, a);
      if (wr) check_eq("busy_wdata", mem_wdata, d);
      check_eq("busy_lv", load_valid, 0);
    end
    if (is_read) exp_rdata = rdv;
    @(negedge clk);
    MemRd = 1'($urandom); MemWr = 1'($urandom); mem_ack = 1'($urandom); mem_rdata = rnd64();
    #1;
    check_eq("done_stall", stall, 0);
    check_eq("done_memreq", mem_req, 0);
    check_eq("done_lv", load_valid, is_read);
    check_eq("done_rdata", rdata_q, exp_rdata);
    check_eq("done_fault", fault, 0);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    MemRd = 0; MemWr = 0; mem_ack = 1'($urandom); mem_rdata = rnd64();
    #1;
    check_eq("idle_stall", stall, 0);
    check_eq("idle_memreq", mem_req, 0);
    check_eq("idle_lv", load_valid, 0);
    check_eq("idle_rdata", rdata_q, exp_rdata);
  endtask

  initial begin
    reset = 1; MemRd = 1; MemWr = 0; addr = 0; wdata = 0; mem_ack = 0; mem_rdata = 0;
    exp_rdata = 0;
    #1;
    check_eq("rst_memreq", mem_req, 0);
    check_eq("rst_we", mem_we, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_wdata", mem_wdata, 0);
    check_eq("rst_rdata", rdata_q, 0);
    check_eq("rst_stall", stall, 0);
    check_eq("rst_lv", load_valid, 0);
    check_eq("rst_fault", fault, 0);
    @(negedge clk);
    reset = 0; MemRd = 0;
    idle_cycle();

    do_access(1, 0, 1, 64'h100, 64'h0, 64'hDEAD_BEEF);
    idle_cycle();
    do_access(0, 1, 3, 64'h40, 64'h1234, rnd64());
    idle_cycle();
    do_access(1, 1, 2, 64'h88, 64'h5555, rnd64());
    do_access(1, 0, 2, 64'h200, 64'h0, 64'hA5A5_0001);
    do_access(1, 0, 1, 64'h208, 64'h0, 64'hA5A5_0002);
    idle_cycle();

    // Reset dropped on the design mid-BUSY, between clock edges.
    @(negedge clk);
    MemRd = 1; MemWr = 0; addr = 64'h300; mem_ack = 0;
    @(negedge clk);
    MemRd = 0;
    #1;
    check_eq("pre_rst_memreq", mem_req, 1);
    #2;
    reset = 1;
    MemRd = 1;
    #1;
    check_eq("midrst_memreq", mem_req, 0);
    check_eq("midrst_stall", stall, 0);
    check_eq("midrst_fault", fault, 0);
    check_eq("midrst_lv", load_valid, 0);
    exp_rdata = 0;
    @(negedge clk);
    reset = 0; MemRd = 0;
    idle_cycle();

    for (int i = 0; i < 40; i++) begin
      int op = $urandom_range(0, 2);
      do_access(op != 1, op != 0, $urandom_range(1, 6), rnd64(), rnd64(), rnd64());
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

`ifdef MEMSEQ_TIMEOUT_EN
    do_access(1, 0, 16, 64'h500, 64'h0, 64'hC0DE_0016);
    idle_cycle();
    @(negedge clk);
    MemRd = 1; MemWr = 0; addr = 64'h600; mem_ack = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      MemRd = 0; mem_ack = 0;
      #1;
      check_eq("to_busy_memreq", mem_req, 1);
      check_eq("to_busy_fault", fault, 0);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mem_ack = 1'($urandom);
      #1;
      check_eq("to_memreq", mem_req, 0);
      check_eq("to_fault", fault, 1);
      check_eq("to_stall", stall, 1);
      check_eq("to_lv", load_valid, 0);
    end
    @(negedge clk);
    reset = 1; mem_ack = 0;
    #1;
    check_eq("to_rst_fault", fault, 0);
    exp_rdata = 0;
    @(negedge clk);
    reset = 0;
    idle_cycle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
